// File: rtl/tc_timer_pkg.sv
// Shared definitions for the tc_timer register block: register indices, MODE codes,
// FSM state encodings and CTRL bit positions.
package tc_timer_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_STATUS = 2'd3;

    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    localparam int TC_CTRL_EN_BIT  = 0;
    localparam int TC_CTRL_MODE_LO = 1;
    localparam int TC_CTRL_MODE_HI = 2;
    localparam int TC_CTRL_IM_BIT  = 3;

    typedef enum logic [1:0] {
        TC_IDLE = 2'b00,
        TC_LOAD = 2'b01,
        TC_CNT  = 2'b10,
        TC_INT  = 2'b11
    } tc_state_e;

endpackage

// File: rtl/tc_timer.sv
// Memory-mapped timer/counter: CTRL/PRESET/COUNT registers, countdown FSM, masked IRQ.
// Optional TC_STATUS_EN macro maps a STATUS register (with write-1 ack) at index 3.
module tc_timer
    import tc_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_e          state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;

    logic [1:0]         idx;
    logic               wr_ctrl, wr_preset, sw_ack, irq_set, irq_drop;
    logic               unused_addr;

    assign idx         = Addr[3:2];
    assign unused_addr = ^Addr[31:4];
    assign wr_ctrl     = WE && (idx == TC_CTRL);
    assign wr_preset   = WE && (idx == TC_PRESET);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_set    = 1'b0;
        irq_drop   = 1'b0;

        case (state_q)
            TC_IDLE: if (en_q) state_d = TC_LOAD;
            TC_LOAD: begin
                count_d = preset_q;
                state_d = TC_CNT;
            end
            TC_CNT: begin
                if (!en_q) begin
                    state_d = TC_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // PRESET of 0 lands here too, so it expires like PRESET of 1.
                    count_d = '0;
                    irq_set = 1'b1;
                    state_d = TC_INT;
                end
            end
            default: begin
                if (mode_q == TC_MODE_RELOAD) begin
                    irq_drop = 1'b1;
                    state_d  = TC_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = TC_IDLE;
                end
            end
        endcase

        // Software writes override the FSM's EN clear in the INT cycle.
        if (wr_ctrl) begin
            en_d   = Din[TC_CTRL_EN_BIT];
            mode_d = Din[TC_CTRL_MODE_HI:TC_CTRL_MODE_LO];
            im_d   = Din[TC_CTRL_IM_BIT];
        end
        if (wr_preset) preset_d = Din[CNT_W-1:0];

`ifdef TC_STATUS_EN
        sw_ack = wr_ctrl || wr_preset || (WE && (idx == TC_STATUS) && Din[0]);
`else
        sw_ack = wr_ctrl || wr_preset;
`endif

        irq_flag_d = irq_flag_q;
        if (irq_drop || sw_ack) irq_flag_d = 1'b0;
        if (irq_set)            irq_flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TC_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        Dout = '0;
        case (idx)
            TC_CTRL: begin
                Dout[TC_CTRL_EN_BIT]                  = en_q;
                Dout[TC_CTRL_MODE_HI:TC_CTRL_MODE_LO] = mode_q;
                Dout[TC_CTRL_IM_BIT]                  = im_q;
            end
            TC_PRESET: Dout[CNT_W-1:0] = preset_q;
            TC_COUNT:  Dout[CNT_W-1:0] = count_q;
            default: begin
`ifdef TC_STATUS_EN
                Dout[4]   = irq_flag_q;
                Dout[2:1] = state_q;
                Dout[0]   = en_q;
`endif
            end
        endcase
    end

    assign IRQ = im_q & irq_flag_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: driver pushes expected Dout/IRQ, a monitor pops and compares.
module tb_tc_timer;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    tc_timer #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_dout_q[$];
    logic        exp_irq_q[$];
    string       exp_name_q[$];
    logic        chk_vld;
    int          total;
    int          bad;

    // Monitor: compares the presented Dout/IRQ mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (chk_vld) begin
            total++;
            if (exp_dout_q.size() == 0) begin
                bad++;
                $display("FAIL no_expectation: dout=%h irq=%b but scoreboard empty", Dout, IRQ);
            end else begin
                logic [31:0] ed;
                logic        ei;
                string       nm;
                ed = exp_dout_q.pop_front();
                ei = exp_irq_q.pop_front();
                nm = exp_name_q.pop_front();
                if (Dout !== ed || IRQ !== ei) begin
                    bad++;
                    $display("FAIL %s: got dout=%h irq=%b, want dout=%h irq=%b", nm, Dout, IRQ, ed, ei);
                end
            end
        end
    end

    task automatic step(input logic [1:0] idx, input logic we, input logic [31:0] din,
                        input logic chk, input logic [31:0] ed, input logic ei, input string nm);
        Addr = {28'd0, idx};
        WE   = we;
        Din  = din;
        if (chk) begin
            exp_dout_q.push_back(ed);
            exp_irq_q.push_back(ei);
            exp_name_q.push_back(nm);
        end
        chk_vld = chk;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] idx, input logic [31:0] ed, input logic ei, input string nm);
        step(idx, 1'b0, 32'd0, 1'b1, ed, ei, nm);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] din);
        step(idx, 1'b1, din, 1'b0, 32'd0, 1'b0, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        chk_vld = 1'b0;
        reset   = 1'b1;
        Addr    = '0;
        WE      = 1'b0;
        Din     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        rd(2'd0, 32'd0, 1'b0, "rst_ctrl");
        rd(2'd1, 32'd0, 1'b0, "rst_preset");
        rd(2'd2, 32'd0, 1'b0, "rst_count");
        rd(2'd3, 32'd0, 1'b0, "rst_idx3");

        // One-shot, PRESET=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        rd(2'd2, 32'd0, 1'b0, "os_idle");
        rd(2'd2, 32'd0, 1'b0, "os_load");
        for (int v = 5; v >= 1; v--) rd(2'd2, 32'(v), 1'b0, "os_count");
        rd(2'd2, 32'd0, 1'b1, "os_int");
        rd(2'd0, 32'h8, 1'b1, "os_ctrl_after");
        rd(2'd0, 32'h8, 1'b1, "os_irq_held");
        step(2'd0, 1'b1, 32'h8, 1'b1, 32'h8, 1'b1, "os_ack_cycle");
        rd(2'd0, 32'h8, 1'b0, "os_acked");

        // Auto-reload, PRESET=3, four periods
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        rd(2'd2, 32'd0, 1'b0, "ar_idle");
        rd(2'd2, 32'd0, 1'b0, "ar_load0");
        for (int p = 0; p < 4; p++) begin
            rd(2'd2, 32'd3, 1'b0, "ar_c3");
            rd(2'd2, 32'd2, 1'b0, "ar_c2");
            rd(2'd2, 32'd1, 1'b0, "ar_c1");
            rd(2'd2, 32'd0, 1'b1, "ar_int");
            rd(2'd2, 32'd0, 1'b0, "ar_reload");
        end
        step(2'd0, 1'b1, 32'h0, 1'b1, 32'hB, 1'b0, "ar_stop_cycle");
        rd(2'd2, 32'd2, 1'b0, "ar_stop_cnt");
        rd(2'd2, 32'd2, 1'b0, "ar_stop_idle");

        // Masked, PRESET=0 behaves like 1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        rd(2'd2, 32'd2, 1'b0, "mk_idle");
        rd(2'd2, 32'd2, 1'b0, "mk_load");
        rd(2'd2, 32'd0, 1'b0, "mk_cnt");
        rd(2'd2, 32'd0, 1'b0, "mk_int_masked");
`ifdef TC_STATUS_EN
        rd(2'd3, 32'h10, 1'b0, "mk_status_flag");
`else
        rd(2'd0, 32'h0, 1'b0, "mk_ctrl_en_clr");
`endif
        wr(2'd0, 32'h8);
        rd(2'd0, 32'h8, 1'b0, "mk_acked");

        // Pause at 7, ignored COUNT write, resume
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        rd(2'd2, 32'd0, 1'b0, "pz_idle");
        rd(2'd2, 32'd0, 1'b0, "pz_load");
        rd(2'd2, 32'd10, 1'b0, "pz_c10");
        rd(2'd2, 32'd9, 1'b0, "pz_c9");
        step(2'd0, 1'b1, 32'h0, 1'b1, 32'h1, 1'b0, "pz_clear_en");
        rd(2'd2, 32'd7, 1'b0, "pz_frozen_cnt");
        rd(2'd2, 32'd7, 1'b0, "pz_frozen_idle");
        step(2'd2, 1'b1, 32'h55, 1'b1, 32'd7, 1'b0, "pz_count_wr");
        rd(2'd2, 32'd7, 1'b0, "pz_count_ro");
        step(2'd0, 1'b1, 32'h1, 1'b1, 32'h0, 1'b0, "pz_resume");
        rd(2'd2, 32'd7, 1'b0, "pz_re_idle");
        rd(2'd2, 32'd7, 1'b0, "pz_re_load");
        for (int v = 10; v >= 1; v--) rd(2'd2, 32'(v), 1'b0, "pz_re_count");
        // CTRL write in the INT cycle wins over the EN clear
        step(2'd0, 1'b1, 32'h9, 1'b1, 32'h1, 1'b0, "col_int_wr");
        rd(2'd0, 32'h9, 1'b0, "col_int_kept");
        step(2'd0, 1'b1, 32'h0, 1'b1, 32'h9, 1'b0, "col_load_clr");
        rd(2'd2, 32'd10, 1'b0, "col_load_done");
        rd(2'd2, 32'd10, 1'b0, "col_exit_idle");

        // Ack in the same cycle as CNT->INT: the set wins
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        rd(2'd2, 32'd10, 1'b0, "set_idle");
        rd(2'd2, 32'd10, 1'b0, "set_load");
        rd(2'd2, 32'd2, 1'b0, "set_c2");
        step(2'd0, 1'b1, 32'h9, 1'b1, 32'h9, 1'b0, "set_ack_c1");
        rd(2'd2, 32'd0, 1'b1, "set_wins");
        rd(2'd0, 32'h8, 1'b1, "set_held");
        step(2'd0, 1'b1, 32'h0, 1'b1, 32'h8, 1'b1, "set_ack");
        rd(2'd0, 32'h0, 1'b0, "set_acked");

`ifdef TC_STATUS_EN
        wr(2'd0, 32'h9);
        rd(2'd3, 32'h1, 1'b0, "st_idle");
        rd(2'd3, 32'h3, 1'b0, "st_load");
        rd(2'd3, 32'h5, 1'b0, "st_cnt2");
        rd(2'd3, 32'h5, 1'b0, "st_cnt1");
        rd(2'd3, 32'h17, 1'b1, "st_int");
        rd(2'd3, 32'h10, 1'b1, "st_held");
        step(2'd3, 1'b1, 32'h1, 1'b1, 32'h10, 1'b1, "st_w1c");
        rd(2'd0, 32'h8, 1'b0, "st_ctrl_same");
`else
        step(2'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, "rsv_wr");
        rd(2'd3, 32'h0, 1'b0, "rsv_rd");
        rd(2'd0, 32'h0, 1'b0, "rsv_ctrl_same");
`endif

        // Reset mid-count with a simultaneous write
        wr(2'd0, 32'h9);
        rd(2'd2, 32'd0, 1'b0, "mr_idle");
        rd(2'd2, 32'd0, 1'b0, "mr_load");
        rd(2'd2, 32'd2, 1'b0, "mr_cnt");
        chk_vld = 1'b0;
        reset   = 1'b1;
        Addr    = '0;
        WE      = 1'b1;
        Din     = 32'hF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(2'd0, 32'd0, 1'b0, "mr_ctrl");
        rd(2'd1, 32'd0, 1'b0, "mr_preset");
        rd(2'd2, 32'd0, 1'b0, "mr_count");
        rd(2'd2, 32'd0, 1'b0, "mr_stays_idle");

        chk_vld = 1'b0;
        WE      = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (exp_dout_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d unchecked entries, want 0", exp_dout_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
